// File: rtl/updown_display.sv
// Display end of the up/down counter's BCD bus: samples COUNT, decodes the step
// direction, flags illegal codes and jumps, and scans a 2-digit 7-segment display.
module updown_display #(
  parameter int SCAN_MAX = 1000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] COUNT,
  output logic [6:0] SEG,
  output logic [1:0] AN,
  output logic       DIR,
  output logic       STEP,
  output logic       ERR
);

  localparam int PW = (SCAN_MAX > 2) ? $clog2(SCAN_MAX) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_MAX - 1);

  localparam logic [6:0] GLYPH_U    = 7'h3E;
  localparam logic [6:0] GLYPH_D    = 7'h5E;
  localparam logic [6:0] GLYPH_DASH = 7'h40;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_HOLD,
    EV_UP,
    EV_DOWN,
    EV_FAULT
  } event_t;

  // Sampling pipeline
  logic [3:0]    r_cur;
  logic [3:0]    r_prev;
  logic          r_valid;
  logic          r_prev_valid;

  // Decoded status
  logic          r_dir;
  logic          r_step;
  logic          r_err;

  // Display scan
  logic [PW-1:0] r_pre;
  logic          r_sel;
  logic [6:0]    r_seg;
  logic [1:0]    r_an;

  logic          w_cur_legal;
  logic          w_prev_legal;
  logic          w_up;
  logic          w_down;
  event_t        w_event;
  logic [6:0]    w_seg_next;
  logic [1:0]    w_an_next;
  logic          w_scan_wrap;

  function automatic logic [6:0] digit_glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'd0:    g = 7'h3F;
      4'd1:    g = 7'h06;
      4'd2:    g = 7'h5B;
      4'd3:    g = 7'h4F;
      4'd4:    g = 7'h66;
      4'd5:    g = 7'h6D;
      4'd6:    g = 7'h7D;
      4'd7:    g = 7'h07;
      4'd8:    g = 7'h7F;
      4'd9:    g = 7'h6F;
      default: g = GLYPH_DASH;
    endcase
    return g;
  endfunction

  assign w_cur_legal  = (r_cur <= 4'd9);
  assign w_prev_legal = (r_prev <= 4'd9);

  // Adjacency on the 0..9 ring, so 9->0 is up and 0->9 is down.
  assign w_up   = (r_prev == 4'd9) ? (r_cur == 4'd0) : (r_cur == r_prev + 4'd1);
  assign w_down = (r_prev == 4'd0) ? (r_cur == 4'd9) : (r_cur == r_prev - 4'd1);

  // r_prev_valid guarantees both samples were taken after reset release, so the
  // reset value of the pipeline is never mistaken for a real count.
  always_comb begin
    w_event = EV_NONE;
    if (r_valid && !w_cur_legal) begin
      w_event = EV_FAULT;
    end else if (r_prev_valid && w_cur_legal && w_prev_legal) begin
      if (r_cur == r_prev) begin
        w_event = EV_HOLD;
      end else if (w_up) begin
        w_event = EV_UP;
      end else if (w_down) begin
        w_event = EV_DOWN;
      end else begin
        w_event = EV_FAULT;
      end
    end
  end

  assign w_scan_wrap = (r_pre == PRE_LAST);

  always_comb begin
    w_seg_next = digit_glyph(r_cur);
    w_an_next  = 2'b10;
    if (r_sel) begin
      w_seg_next = r_dir ? GLYPH_U : GLYPH_D;
      w_an_next  = 2'b01;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_cur        <= 4'd0;
      r_prev       <= 4'd0;
      r_valid      <= 1'b0;
      r_prev_valid <= 1'b0;
    end else begin
      r_cur        <= COUNT;
      r_prev       <= r_cur;
      r_valid      <= 1'b1;
      r_prev_valid <= r_valid;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_dir  <= 1'b1;
      r_step <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_step <= 1'b0;
      unique case (w_event)
        EV_UP: begin
          r_step <= 1'b1;
          r_dir  <= 1'b1;
        end
        EV_DOWN: begin
          r_step <= 1'b1;
          r_dir  <= 1'b0;
        end
        EV_FAULT: r_err <= 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_pre <= '0;
      r_sel <= 1'b0;
      r_seg <= 7'h00;
      r_an  <= 2'b11;
    end else begin
      r_pre <= w_scan_wrap ? '0 : r_pre + 1'b1;
      if (w_scan_wrap) begin
        r_sel <= ~r_sel;
      end
      r_seg <= w_seg_next;
      r_an  <= w_an_next;
    end
  end

  assign SEG  = r_seg;
  assign AN   = r_an;
  assign DIR  = r_dir;
  assign STEP = r_step;
  assign ERR  = r_err;

endmodule

// File: tb/tb_updown_display.sv
// Scoreboard bench for updown_display: directed scenarios then random counter
// traffic, checked cycle by cycle against a sample-history reference model.
module tb_updown_display;
  localparam int SCAN = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] count;
  logic [6:0] seg;
  logic [1:0] an;
  logic       dir;
  logic       step;
  logic       err;

  updown_display #(.SCAN_MAX(SCAN)) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .COUNT (count),
    .SEG   (seg),
    .AN    (an),
    .DIR   (dir),
    .STEP  (step),
    .ERR   (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         tag;
    logic [6:0] seg;
    logic [1:0] an;
    logic       dir;
    logic       step;
    logic       err;
  } exp_t;

  localparam logic [6:0] GLYPH [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   stim_edge = 0;
  int   mon_edge = 0;

  // Reference model: post-reset sample history, cycles since release, flags.
  int   hist[$];
  int   since = 0;
  logic m_dir = 1'b1;
  logic m_err = 1'b0;
  int   cv = 0;

  function automatic logic [6:0] glyph(input int v);
    if (v > 9) return 7'h40;
    return GLYPH[v];
  endfunction

  task automatic cycle(input logic r, input int c);
    exp_t e;
    int   cur;
    int   prev;
    int   d;
    int   sel;
    rst_n = r;
    count = c[3:0];
    stim_edge++;
    e.tag  = stim_edge;
    e.step = 1'b0;
    if (!r) begin
      hist.delete();
      since = 0;
      m_dir = 1'b1;
      m_err = 1'b0;
      e.seg = 7'h00;
      e.an  = 2'b11;
    end else begin
      since++;
      sel = ((since - 1) / SCAN) % 2;
      cur = 0;
      if (hist.size() >= 1) cur = hist[hist.size()-1];
      e.an  = (sel == 1) ? 2'b01 : 2'b10;
      e.seg = (sel == 1) ? (m_dir ? 7'h3E : 7'h5E) : glyph(cur);
      if (hist.size() >= 1 && cur > 9) begin
        m_err = 1'b1;
      end else if (hist.size() >= 2) begin
        prev = hist[hist.size()-2];
        if (prev <= 9) begin
          d = (cur - prev + 10) % 10;
          if (d == 1) begin
            e.step = 1'b1;
            m_dir  = 1'b1;
          end else if (d == 9) begin
            e.step = 1'b1;
            m_dir  = 1'b0;
          end else if (d != 0) begin
            m_err = 1'b1;
          end
        end
      end
      hist.push_back(c);
      if (hist.size() > 2) void'(hist.pop_front());
    end
    e.dir = m_dir;
    e.err = m_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic r, input int c, input int n);
    for (int i = 0; i < n; i++) cycle(r, c);
    cv = c;
  endtask

  // Monitor: compares every edge's outputs against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      mon_edge++;
      @(negedge clk);
      while (sb.size() > 0 && sb[0].tag <= mon_edge) begin
        e = sb.pop_front();
        checks++;
        if (seg !== e.seg || an !== e.an || dir !== e.dir || step !== e.step || err !== e.err) begin
          errors++;
          $display("FAIL edge%0d outputs: got seg=%h an=%b dir=%b step=%b err=%b, want seg=%h an=%b dir=%b step=%b err=%b",
                   e.tag, seg, an, dir, step, err, e.seg, e.an, e.dir, e.step, e.err);
        end else begin
          $display("edge%0d ok: seg=%h an=%b dir=%b step=%b err=%b", e.tag, seg, an, dir, step, err);
        end
      end
    end
  end

  initial begin
    int r;
    int nxt;
    rst_n = 1'b0;
    count = 4'd0;
    // Reset and idle scan
    hold(1'b0, 0, 3);
    hold(1'b1, 0, 20);
    // Up with wrap
    hold(1'b0, 7, 2);
    hold(1'b1, 7, 5);
    hold(1'b1, 8, 5);
    hold(1'b1, 9, 5);
    hold(1'b1, 0, 5);
    // Down with wrap
    hold(1'b0, 2, 2);
    hold(1'b1, 2, 5);
    hold(1'b1, 1, 5);
    hold(1'b1, 0, 5);
    hold(1'b1, 9, 10);
    // Jump
    hold(1'b0, 3, 2);
    hold(1'b1, 3, 5);
    hold(1'b1, 6, 8);
    // Illegal code, then a down step to give DIR=0 with ERR=1
    hold(1'b0, 5, 2);
    hold(1'b1, 5, 5);
    hold(1'b1, 12, 3);
    hold(1'b1, 4, 5);
    hold(1'b1, 3, 5);
    // Reset mid-run
    hold(1'b0, 3, 1);
    hold(1'b1, 5, 10);
    // Random counter traffic
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 40)      nxt = cv;
      else if (r < 65) nxt = (cv > 9) ? 0 : (cv + 1) % 10;
      else if (r < 85) nxt = (cv > 9) ? 9 : (cv + 9) % 10;
      else if (r < 92) nxt = $urandom_range(0, 9);
      else if (r < 97) nxt = $urandom_range(10, 15);
      else             nxt = -1;
      if (nxt < 0) hold(1'b0, cv, 1);
      else         hold(1'b1, nxt, $urandom_range(1, 3));
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
